// File: rtl/sha3_seq_pkg.sv
`default_nettype none
//============================================================================
// sha3_seq_pkg - shared state encoding and widths for sha3_msg_sequencer
// Rev 1.0
//============================================================================
package sha3_seq_pkg;
  localparam int WORD_W     = 32;
  localparam int DIGEST_W   = 512;
  localparam int BYTE_NUM_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_DIG = 3'd2,
    DONE     = 3'd3,
    CLR      = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/sha3_seq_word_counter.sv
`default_nettype none
//============================================================================
// sha3_seq_word_counter - full-word down-counter, tail bytes and last flag
// Rev 1.0
//============================================================================
module sha3_seq_word_counter
  import sha3_seq_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LEN_W-1:0]      len,
  input  logic                  dec,
  output logic [BYTE_NUM_W-1:0] tail,
  output logic                  last_word
);

  logic [LEN_W-3:0] count;

  // The final push happens with count already at zero, so it must not wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tail  <= '0;
    end else if (load) begin
      count <= len[LEN_W-1:2];
      tail  <= len[1:0];
    end else if (dec && (count != '0)) begin
      count <= count - (LEN_W-2)'(1);
    end
  end

  assign last_word = (count == '0);

endmodule
`default_nettype wire

// File: rtl/sha3_msg_sequencer.sv
`default_nettype none
//============================================================================
// sha3_msg_sequencer - streams one message into sha3_low_throughput, returns digest
// Rev 1.0 | optional watchdog + err port: `define SHA3_SEQ_TIMEOUT_EN
//============================================================================
module sha3_msg_sequencer
  import sha3_seq_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int CLR_CYCLES  = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [LEN_W-1:0]      start_len,
  input  logic [WORD_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  core_reset,
  output logic [WORD_W-1:0]     core_in,
  output logic                  core_in_ready,
  output logic                  core_is_last,
  output logic [BYTE_NUM_W-1:0] core_byte_num,
  input  logic                  core_buffer_full,
  input  logic [DIGEST_W-1:0]   core_out,
  input  logic                  core_out_ready,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [DIGEST_W-1:0]   dig_data,
  output logic                  busy
`ifdef SHA3_SEQ_TIMEOUT_EN
  ,
  output logic                  err
`endif
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t                  state;
  logic [CLR_W-1:0]        clr_cnt;
  logic [BYTE_NUM_W-1:0]   tail;
  logic                    last_word;
  logic                    in_load;
  logic                    synth;
  logic                    push;
  logic                    load;

  sha3_seq_word_counter #(.LEN_W(LEN_W)) u_word_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .len       (start_len),
    .dec       (push),
    .tail      (tail),
    .last_word (last_word)
  );

  // Handshake outputs are gated by reset so they read as idle during it.
  assign in_load       = (state == LOAD) && !reset;
  assign synth         = in_load && last_word && (tail == '0);
  assign push          = in_load && !core_buffer_full && (synth || s_valid);
  assign load          = (state == IDLE) && start_valid;
  assign s_ready       = push && !synth;
  assign core_in_ready = push;
  assign core_in       = synth ? '0 : s_data;
  assign core_is_last  = in_load && last_word;
  assign core_byte_num = core_is_last ? tail : '0;
  assign core_reset    = reset || (state == CLR);
  assign start_ready   = (state == IDLE) && !reset;
  assign busy          = (state != IDLE);

`ifdef SHA3_SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      dig_valid <= 1'b0;
      dig_data  <= '0;
`ifdef SHA3_SEQ_TIMEOUT_EN
      wd_cnt    <= '0;
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state <= LOAD;
`ifdef SHA3_SEQ_TIMEOUT_EN
            err   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (push && last_word) begin
            state <= WAIT_DIG;
`ifdef SHA3_SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        WAIT_DIG: begin
          if (core_out_ready) begin
            dig_data  <= core_out;
            dig_valid <= 1'b1;
            state     <= DONE;
          end
`ifdef SHA3_SEQ_TIMEOUT_EN
          else if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
            err     <= 1'b1;
            clr_cnt <= '0;
            state   <= CLR;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        DONE: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            clr_cnt   <= '0;
            state     <= CLR;
          end
        end
        CLR: begin
          // Core out_ready stays high until its reset, so hold it long enough.
          if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha3_msg_sequencer.sv
`default_nettype none
//============================================================================
// tb_sha3_msg_sequencer - table/scoreboard bench for sha3_msg_sequencer
// Rev 1.0
//============================================================================
module tb_sha3_msg_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [15:0]  start_len;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic         core_reset;
  logic [31:0]  core_in;
  logic         core_in_ready;
  logic         core_is_last;
  logic [1:0]   core_byte_num;
  logic         core_buffer_full;
  logic [511:0] core_out;
  logic         core_out_ready;
  logic         dig_valid;
  logic         dig_ready;
  logic [511:0] dig_data;
  logic         busy;
`ifdef SHA3_SEQ_TIMEOUT_EN
  logic         err;
`endif

  sha3_msg_sequencer #(.LEN_W(16), .CLR_CYCLES(2), .TIMEOUT_CYC(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_valid      (start_valid),
    .start_ready      (start_ready),
    .start_len        (start_len),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .core_reset       (core_reset),
    .core_in          (core_in),
    .core_in_ready    (core_in_ready),
    .core_is_last     (core_is_last),
    .core_byte_num    (core_byte_num),
    .core_buffer_full (core_buffer_full),
    .core_out         (core_out),
    .core_out_ready   (core_out_ready),
    .dig_valid        (dig_valid),
    .dig_ready        (dig_ready),
    .dig_data         (dig_data),
    .busy             (busy)
`ifdef SHA3_SEQ_TIMEOUT_EN
    ,
    .err              (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  bnum;
    logic        synth;
  } push_t;

  typedef struct {
    int          len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] seed;
    int          exp_push;
    int          exp_cons;
    bit          early;
  } vec_t;

  push_t        exp_q[$];
  logic [31:0]  src_q[$];
  push_t        mon_p;
  int           n_vec = 0;
  int           n_fail = 0;
  int           n_push = 0;
  int           n_cons = 0;
  int           base_push = 0;
  int           base_cons = 0;
  int           model_cd = 0;
  bit           took = 0;
  bit           last_seen = 0;
  bit           dig_seen = 0;
  bit           core_en = 1;
  logic [511:0] exp_dig = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Push monitor: every core push is matched against the scoreboard.
  always @(negedge clk) begin
    took = s_valid && s_ready;
    if (took) n_cons++;
    if (dig_valid) dig_seen = 1;
    if (core_in_ready) begin
      n_push++;
      check("push_not_full", core_buffer_full, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_push", exp_q.size(), 0);
      end else begin
        mon_p = exp_q.pop_front();
        check("push_data", core_in, mon_p.data);
        check("push_is_last", core_is_last, mon_p.last);
        check("push_byte_num", core_byte_num, mon_p.bnum);
        check("push_s_ready", s_ready, !mon_p.synth);
        if (core_is_last) last_seen = 1;
      end
    end
  end

  // Upstream source
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (took && src_q.size() > 0) void'(src_q.pop_front());
      s_valid = (src_q.size() > 0);
      s_data  = s_valid ? src_q[0] : 32'h0;
    end
  end

  // Core model: digest a few cycles after the last word, held until core reset.
  initial begin
    core_out_ready = 1'b0;
    core_out       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (core_reset) begin
        core_out_ready = 1'b0;
        model_cd       = 0;
        last_seen      = 0;
      end else if (last_seen && core_en) begin
        last_seen = 0;
        model_cd  = 3;
      end else if (model_cd > 0) begin
        model_cd--;
        if (model_cd == 0) begin
          core_out_ready = 1'b1;
          core_out       = exp_dig;
        end
      end
    end
  end

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return v.seed + 32'(i);
  endfunction

  task automatic begin_msg(input vec_t v);
    int    nf = v.len / 4;
    int    tl = v.len % 4;
    push_t e;
    for (int i = 0; i < nf; i++) begin
      e.data = word_of(v, i); e.last = 1'b0; e.bnum = 2'd0; e.synth = 1'b0;
      exp_q.push_back(e);
      src_q.push_back(e.data);
    end
    if (tl != 0) begin
      e.data = word_of(v, nf); e.last = 1'b1; e.bnum = 2'(tl); e.synth = 1'b0;
      src_q.push_back(e.data);
    end else begin
      e.data = 32'h0; e.last = 1'b1; e.bnum = 2'd0; e.synth = 1'b1;
    end
    exp_q.push_back(e);
    for (int i = 0; i < 16; i++) exp_dig[i*32 +: 32] = $urandom();
    base_push = n_push;
    base_cons = n_cons;
    check("start_ready_idle", start_ready, 1'b1);
    start_valid = 1'b1;
    start_len   = 16'(v.len);
    dig_ready   = v.early;
    step();
    start_valid = 1'b0;
  endtask

  task automatic wait_dig();
    int k = 0;
    while (!dig_valid && k < 300) begin
      step();
      k++;
    end
    check("dig_valid_seen", dig_valid, 1'b1);
    check("dig_data", dig_data, exp_dig);
  endtask

  task automatic accept_and_clear();
    int n = 0;
    dig_ready = 1'b1;
    step();
    dig_ready = 1'b0;
    check("dig_valid_cleared", dig_valid, 1'b0);
    while (core_reset && n < 20) begin
      n++;
      step();
    end
    check("clr_cycles", n, 2);
    check("start_ready_after_clr", start_ready, 1'b1);
  endtask

  task automatic finish_counts(input int ep, input int ec);
    check("push_count", n_push - base_push, ep);
    check("upstream_count", n_cons - base_cons, ec);
    check("scoreboard_empty", exp_q.size(), 0);
`ifdef SHA3_SEQ_TIMEOUT_EN
    check("err_clear", err, 1'b0);
`endif
  endtask

  vec_t vt[8];
  vec_t vs;

  initial begin
    int k;
    int hp;
    reset            = 1'b1;
    start_valid      = 1'b0;
    start_len        = '0;
    core_buffer_full = 1'b0;
    dig_ready        = 1'b0;

    vt[0] = '{5,  32'h61626364, 32'h65000000, 32'h0,        2, 2, 1'b0};
    vt[1] = '{8,  32'h11223344, 32'h55667788, 32'h0,        3, 2, 1'b0};
    vt[2] = '{0,  32'h0,        32'h0,        32'h0,        1, 0, 1'b0};
    vt[3] = '{3,  32'hAABBCCDD, 32'h0,        32'h0,        1, 1, 1'b0};
    vt[4] = '{4,  32'hDEADBEEF, 32'h0,        32'h0,        2, 1, 1'b0};
    vt[5] = '{13, 32'h01020304, 32'h05060708, 32'h30000000, 4, 4, 1'b0};
    vt[6] = '{16, 32'hCAFEF00D, 32'h0BADC0DE, 32'h40000000, 5, 4, 1'b1};
    vt[7] = '{7,  32'h13579BDF, 32'h2468ACE0, 32'h0,        2, 2, 1'b1};

    // Reset state
    repeat (3) step();
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_core_in_ready", core_in_ready, 1'b0);
    check("rst_dig_valid", dig_valid, 1'b0);
    check("rst_dig_data", dig_data, 512'h0);
    reset = 1'b0;
    step();
    check("post_rst_core_reset", core_reset, 1'b0);
    check("post_rst_start_ready", start_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_is_last", core_is_last, 1'b0);
    check("post_rst_byte_num", core_byte_num, 2'd0);

    // Table-driven messages
    for (int i = 0; i < 8; i++) begin
      begin_msg(vt[i]);
      check("busy_in_msg", busy, 1'b1);
      wait_dig();
      accept_and_clear();
      finish_counts(vt[i].exp_push, vt[i].exp_cons);
    end

    // Core backpressure for 10 cycles mid-LOAD
    vs = '{16, 32'h10000001, 32'h10000002, 32'h10000000, 5, 4, 1'b0};
    begin_msg(vs);
    k = 0;
    while (n_push - base_push < 2 && k < 50) begin step(); k++; end
    core_buffer_full = 1'b1;
    hp = n_push;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_s_valid", s_valid, 1'b1);
      check("stall_s_ready", s_ready, 1'b0);
      check("stall_core_in_ready", core_in_ready, 1'b0);
      step();
    end
    check("stall_push_hold", n_push, hp);
    core_buffer_full = 1'b0;
    wait_dig();
    accept_and_clear();
    finish_counts(5, 4);

    // Digest backpressure; a start command meanwhile must be ignored
    vs = '{4, 32'h77777777, 32'h0, 32'h0, 2, 1, 1'b0};
    begin_msg(vs);
    wait_dig();
    hp = n_push;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin start_valid = 1'b1; start_len = 16'd8; end
      if (i == 5) start_valid = 1'b0;
      #1;
      check("hold_dig_valid", dig_valid, 1'b1);
      check("hold_dig_data", dig_data, exp_dig);
      check("hold_start_ready", start_ready, 1'b0);
      step();
    end
    start_valid = 1'b0;
    check("hold_no_push", n_push, hp);
    accept_and_clear();
    finish_counts(2, 1);

    // Reset in the middle of LOAD after 3 pushes
    vs = '{20, 32'h20000000, 32'h20000001, 32'h20000000, 6, 5, 1'b0};
    begin_msg(vs);
    k = 0;
    while (n_push - base_push < 3 && k < 50) begin step(); k++; end
    reset = 1'b1;
    #1;
    check("midrst_core_reset", core_reset, 1'b1);
    check("midrst_core_in_ready", core_in_ready, 1'b0);
    check("midrst_s_ready", s_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_start_ready", start_ready, 1'b1);
    check("midrst_dig_valid", dig_valid, 1'b0);
    check("midrst_core_reset_low", core_reset, 1'b0);
    check("midrst_is_last", core_is_last, 1'b0);
    check("midrst_byte_num", core_byte_num, 2'd0);
    check("midrst_push_count", n_push - base_push, 3);
    src_q.delete();
    exp_q.delete();
    last_seen = 0;
    vs = '{4, 32'h0A0B0C0D, 32'h0, 32'h0, 2, 1, 1'b0};
    begin_msg(vs);
    wait_dig();
    accept_and_clear();
    finish_counts(2, 1);

`ifdef SHA3_SEQ_TIMEOUT_EN
    // Watchdog: no digest ever arrives
    core_en  = 0;
    dig_seen = 0;
    vs = '{0, 32'h0, 32'h0, 32'h0, 1, 0, 1'b0};
    begin_msg(vs);
    k = 0;
    while (!err && k < 100) begin step(); k++; end
    check("timeout_cycles", k, 17);
    check("timeout_err", err, 1'b1);
    hp = 0;
    while (core_reset && hp < 20) begin hp++; step(); end
    check("timeout_clr_cycles", hp, 2);
    check("timeout_start_ready", start_ready, 1'b1);
    check("timeout_err_sticky", err, 1'b1);
    check("timeout_no_digest", dig_seen, 1'b0);
    core_en = 1;
    vs = '{4, 32'h5A5A5A5A, 32'h0, 32'h0, 2, 1, 1'b0};
    begin_msg(vs);
    check("err_cleared_on_start", err, 1'b0);
    wait_dig();
    accept_and_clear();
    finish_counts(2, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
